// File: rtl/imem_loader_if.sv
// Loader-side bundle: inbound byte stream (valid/ready) and outbound instruction-memory write port.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        input  byte_data, byte_valid,
        output byte_ready, we, waddr, wdata
    );

    modport slave (
        output byte_data, byte_valid,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream, packs it little-endian into 32-bit words and writes
// them to instruction memory from address 0, holding the core in reset until the load is done.
module imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    imem_loader_if.master bus,
    output logic          cpu_rst_no,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [15:0]   words_o
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] widx_q, widx_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;

    logic        accept;
    logic        in_range;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            len_q   <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    // Guards the write so an oversized frame never aliases onto low addresses.
    assign in_range = (widx_q < DEPTH[15:0]);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        lane_d  = lane_q;
        word_d  = word_q;
        err_d   = err_q;
        words_d = words_q;
        accept  = bus.byte_valid &&
                  (state_q == StLenLo || state_q == StLenHi || state_q == StData);

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLenLo;
                    err_d   = 1'b0;
                    words_d = '0;
                    widx_d  = '0;
                    lane_d  = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = bus.byte_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = bus.byte_data;
                    state_d     = ({bus.byte_data, len_q[7:0]} == 16'd0) ? StDone : StData;
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{lane_q, 3'b000} +: 8] = bus.byte_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                if (in_range) words_d = words_q + 16'd1;
                else          err_d   = 1'b1;
                widx_d  = widx_q + 16'd1;
                lane_d  = '0;
                state_d = (widx_q + 16'd1 == len_q) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        bus.waddr      = widx_q[ADDR_W-1:0];
        bus.wdata      = word_q;
        cpu_rst_no     = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        err_o          = err_q;
        words_o        = words_q;

        unique case (state_q)
            StLenLo, StLenHi, StData: begin
                bus.byte_ready = 1'b1;
                busy_o         = 1'b1;
            end
            StWrite: begin
                bus.we = in_range;
                busy_o = 1'b1;
            end
            StDone: begin
                done_o     = 1'b1;
                cpu_rst_no = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
